// File: rtl/truth_table_sweeper.sv
// Programmable N-input truth table that sweeps every input combination onto a valid/ready stream.
// Optional ones counter output enabled by defining TTS_ONES_COUNT_EN.
module truth_table_sweeper #(
  parameter int N = 2,
  parameter logic [(1<<N)-1:0] TT_INIT = {{((1<<N)-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [(1<<N)-1:0] cfg_tt,
  input  logic              start,
  output logic              busy,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [N-1:0]      out_x,
  output logic              out_s,
  output logic              done
`ifdef TTS_ONES_COUNT_EN
  ,
  output logic [N:0]        ones_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [N:0] LAST = (N+1)'((1 << N) - 1);

  state_t            state;
  state_t            state_nxt;
  logic [(1<<N)-1:0] tt;
  logic [N:0]        idx;
  logic [N:0]        idx_inc;
  logic              go;
  logic              xfer;
  logic              last_xfer;

  always_comb begin
    go        = (state == S_IDLE) && start;
    xfer      = (state == S_RUN) && out_rdy;
    last_xfer = xfer && (idx == LAST);
    idx_inc   = idx + (N+1)'(1);
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_vld   = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        out_vld = 1'b1;
        if (last_xfer) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // out_s is preloaded from cfg_tt when a load and start coincide, so the sweep sees the new table.
  always_ff @(posedge clk) begin
    if (reset) begin
      tt    <= TT_INIT;
      idx   <= '0;
      out_x <= '0;
      out_s <= 1'b0;
    end else begin
      if ((state == S_IDLE) && cfg_we) tt <= cfg_tt;
      if (go) begin
        idx   <= '0;
        out_x <= '0;
        out_s <= cfg_we ? cfg_tt[0] : tt[0];
      end else if (xfer) begin
        idx <= idx_inc;
        if (!last_xfer) begin
          out_x <= idx_inc[N-1:0];
          out_s <= tt[idx_inc[N-1:0]];
        end
      end
    end
  end

`ifdef TTS_ONES_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_cnt <= '0;
    end else if (go) begin
      ones_cnt <= '0;
    end else if (xfer && out_s) begin
      ones_cnt <= ones_cnt + (N+1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: expected pairs are queued per sweep from the table
// contents, and monitors compare whatever the DUT presents on its output stream.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [3:0] cfg_tt;
  logic       start;
  logic       busy;
  logic       out_vld;
  logic       out_rdy = 1'b1;
  logic [1:0] out_x;
  logic       out_s;
  logic       done;

  logic       cfg_we2;
  logic [7:0] cfg_tt2;
  logic       start2;
  logic       busy2;
  logic       out_vld2;
  logic       out_rdy2 = 1'b1;
  logic [2:0] out_x2;
  logic       out_s2;
  logic       done2;
`ifdef TTS_ONES_COUNT_EN
  logic [2:0] ones_cnt;
  logic [3:0] ones_cnt2;
`endif

  always #5 clk = ~clk;

  truth_table_sweeper dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_tt(cfg_tt), .start(start),
    .busy(busy), .out_vld(out_vld), .out_rdy(out_rdy), .out_x(out_x), .out_s(out_s),
    .done(done)
`ifdef TTS_ONES_COUNT_EN
    , .ones_cnt(ones_cnt)
`endif
  );

  truth_table_sweeper #(.N(3), .TT_INIT(8'b1000_0000)) dut3 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we2), .cfg_tt(cfg_tt2), .start(start2),
    .busy(busy2), .out_vld(out_vld2), .out_rdy(out_rdy2), .out_x(out_x2), .out_s(out_s2),
    .done(done2)
`ifdef TTS_ONES_COUNT_EN
    , .ones_cnt(ones_cnt2)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] q1[$];
  logic [3:0] q2[$];
  logic [3:0] model_tt;
  int xfers1 = 0;
  int xfers2 = 0;
  int rdy_mode = 0;
  int hold_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ready pattern: 0 always, 1 random, 2 stalled, 3 stall three cycles on out_x==01.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_rdy = 1'b1;
      1: out_rdy = 1'($urandom_range(0, 1));
      2: out_rdy = 1'b0;
      default: begin
        if (out_vld && out_x == 2'd1 && hold_cnt < 3) begin
          out_rdy = 1'b0;
          hold_cnt++;
        end else begin
          out_rdy = 1'b1;
        end
      end
    endcase
    out_rdy2 = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!reset && out_vld) begin
      if (q1.size() == 0) begin
        chk("unexpected_vld", 1, 0);
      end else begin
        chk("pair_x", int'(out_x), int'(q1[0][2:1]));
        chk("pair_s", int'(out_s), int'(q1[0][0]));
        if (out_rdy) begin
          void'(q1.pop_front());
          xfers1++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_vld2) begin
      if (q2.size() == 0) begin
        chk("unexpected_vld3", 1, 0);
      end else begin
        chk("pair3_x", int'(out_x2), int'(q2[0][3:1]));
        chk("pair3_s", int'(out_s2), int'(q2[0][0]));
        if (out_rdy2) begin
          void'(q2.pop_front());
          xfers2++;
        end
      end
    end
  end

  task automatic do_sweep(input bit load, input logic [3:0] new_tt, input int rmode,
                          input bit inject);
    int vcyc;
    bit seen_done;
    logic [3:0] used_tt;
    rdy_mode = rmode;
    hold_cnt = 0;
    @(posedge clk); #1;
    if (load) begin
      cfg_we   = 1'b1;
      cfg_tt   = new_tt;
      model_tt = new_tt;
    end
    start   = 1'b1;
    used_tt = model_tt;
    for (int i = 0; i < 4; i++) q1.push_back({2'(i), used_tt[i]});
    xfers1 = 0;
    @(posedge clk); #1;
    start  = 1'b0;
    cfg_we = 1'b0;
    @(negedge clk);
    chk("latency_vld", int'(out_vld), 1);
    chk("latency_x", int'(out_x), 0);
    chk("busy_run", int'(busy), 1);
    vcyc = 1;
    seen_done = 1'b0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (inject && c == 1) begin
        start  = 1'b1;
        cfg_we = 1'b1;
        cfg_tt = 4'b1111;
      end else begin
        start  = 1'b0;
        cfg_we = 1'b0;
      end
      @(negedge clk);
      if (done) seen_done = 1'b1;
      else if (out_vld) vcyc++;
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    if (!seen_done) chk("done_timeout", 0, 1);
    chk("queue_drained", q1.size(), 0);
    chk("xfers", xfers1, 4);
    if (rmode == 0) chk("full_rate_cycles", vcyc, 4);
    if (rmode == 3) chk("stall_cycles", vcyc, 7);
`ifdef TTS_ONES_COUNT_EN
    chk("ones_cnt", int'(ones_cnt), $countones(used_tt));
`endif
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("busy_after", int'(busy), 0);
    chk("vld_after", int'(out_vld), 0);
    if (inject) begin
      repeat (3) begin
        @(negedge clk);
        chk("no_queued_start", int'(busy), 0);
      end
    end
  endtask

  task automatic sweep3();
    bit seen_done;
    @(posedge clk); #1;
    start2 = 1'b1;
    for (int i = 0; i < 8; i++) q2.push_back({3'(i), (i == 7) ? 1'b1 : 1'b0});
    xfers2 = 0;
    @(posedge clk); #1;
    start2 = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      @(negedge clk);
      if (done2) seen_done = 1'b1;
    end
    if (!seen_done) chk("done3_timeout", 0, 1);
    chk("queue3_drained", q2.size(), 0);
    chk("xfers3", xfers2, 8);
`ifdef TTS_ONES_COUNT_EN
    chk("ones_cnt3", int'(ones_cnt2), 1);
`endif
    @(negedge clk);
    chk("busy3_after", int'(busy2), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1; cfg_we = 1'b0; cfg_tt = '0; start = 1'b0;
    cfg_we2 = 1'b0; cfg_tt2 = '0; start2 = 1'b0;
    model_tt = 4'b0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vld", int'(out_vld), 0);
    chk("rst_x", int'(out_x), 0);
    chk("rst_s", int'(out_s), 0);
    chk("rst_done", int'(done), 0);
`ifdef TTS_ONES_COUNT_EN
    chk("rst_ones", int'(ones_cnt), 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    do_sweep(1'b0, 4'b0000, 0, 1'b0);
    do_sweep(1'b0, 4'b0000, 3, 1'b0);
    do_sweep(1'b0, 4'b0000, 0, 1'b1);
    do_sweep(1'b0, 4'b0000, 1, 1'b0);
    do_sweep(1'b1, 4'b0110, 0, 1'b0);

    // Mid-sweep reset with the XOR table loaded; the default table must come back.
    rdy_mode = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) q1.push_back({2'(i), model_tt[i]});
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (out_vld && out_x == 2'd2) found = 1'b1;
    end
    if (!found) chk("t5_reach", 0, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q1.delete();
    model_tt = 4'b0001;
    @(negedge clk);
    chk("t5_vld", int'(out_vld), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_x", int'(out_x), 0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_done", int'(done), 0);
    end
    do_sweep(1'b0, 4'b0000, 0, 1'b0);

    repeat (8) do_sweep(1'($urandom_range(0, 1)), 4'($urandom), 1, 1'b0);

    sweep3();
    sweep3();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
